fft_seq_ctrl: RTL

//  Parametrised sequencer for the FFT accelerator: loads N complex samples into the in-place RAM in bit-reversed order, runs log2(N) radix-2 DIT stages through a pipelined butterfly, then streams results out.

---
 rtl/fft_seq_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/fft_seq_ctrl.sv
// Sequencer for the in-place radix-2 DIT FFT: bit-reversed load, log2(N) butterfly
// stages with a write-back delay line and hazard drain, then natural-order unload.
module fft_seq_ctrl #(
  parameter int N_POINTS = 1024,
  parameter int BF_LAT   = 2,
  parameter int SIG_W    = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          is_ifft,
  input  logic [SIG_W-1:0]              sig_num,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [$clog2(N_POINTS)-1:0]   rd_addr_a,
  output logic [$clog2(N_POINTS)-1:0]   rd_addr_b,
  output logic                          rd_en,
  output logic [$clog2(N_POINTS)-1:0]   wr_addr_a,
  output logic [$clog2(N_POINTS)-1:0]   wr_addr_b,
  output logic                          wr_en,
  output logic                          wr_sel_ext,
  output logic [$clog2(N_POINTS)-2:0]   tw_idx,
  output logic                          conj_tw,
  output logic                          busy,
  output logic                          done,
  output logic [SIG_W-1:0]              sig_num_out
);

  localparam int LOG2N = $clog2(N_POINTS);
  localparam int SW    = $clog2(LOG2N);
  localparam int DW    = $clog2(BF_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DRAIN, S_UNLOAD} state_t;

  state_t                         state_q, state_d;
  logic [LOG2N-1:0]               ld_cnt_q, ld_cnt_d;
  logic [LOG2N-2:0]               cyc_q, cyc_d;
  logic [SW-1:0]                  stage_q, stage_d;
  logic [DW-1:0]                  drn_q, drn_d;
  logic [LOG2N:0]                 un_cnt_q, un_cnt_d;
  logic                           out_valid_q, out_valid_d;
  logic                           conj_q, conj_d;
  logic [SIG_W-1:0]               sig_q, sig_d;
  logic [BF_LAT-1:0]              vld_pipe_q, vld_pipe_d;
  logic [BF_LAT-1:0][LOG2N-1:0]   pa_q, pa_d, pb_q, pb_d;

  logic             ld_beat, cyc_last, stage_last, drn_last, un_issue, un_last;
  logic [LOG2N-1:0] ld_rev, lo_mask, cyc_w, calc_a, calc_b;
  logic [LOG2N-2:0] calc_tw;
  logic [SW-1:0]    tw_sh;

  assign ld_beat    = (state_q == S_LOAD) && in_valid;
  assign cyc_last   = &cyc_q;
  assign stage_last = (stage_q == SW'(LOG2N - 1));
  assign drn_last   = (drn_q == DW'(BF_LAT - 1));
  // un_cnt reaches N once every read is issued; the MSB marks that point
  assign un_issue   = (state_q == S_UNLOAD) && !un_cnt_q[LOG2N] && (!out_valid_q || out_ready);
  assign un_last    = (state_q == S_UNLOAD) && out_valid_q && out_ready && un_cnt_q[LOG2N];

  // grp*2*half + pos == upper cyc bits shifted up by one, low stage bits kept
  always_comb begin
    ld_rev = '0;
    for (int i = 0; i < LOG2N; i++) ld_rev[i] = ld_cnt_q[LOG2N-1-i];
    lo_mask = ~({LOG2N{1'b1}} << stage_q);
    cyc_w   = {1'b0, cyc_q};
    calc_a  = ((cyc_w & ~lo_mask) << 1) | (cyc_w & lo_mask);
    calc_b  = calc_a | ({{(LOG2N-1){1'b0}}, 1'b1} << stage_q);
    tw_sh   = SW'(LOG2N - 1) - stage_q;
    calc_tw = (cyc_q & lo_mask[LOG2N-2:0]) << tw_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:   if (start) state_d = S_LOAD;
        S_LOAD:   if (ld_beat && (ld_cnt_q == {LOG2N{1'b1}})) state_d = S_CALC;
        S_CALC:   if (cyc_last) state_d = S_DRAIN;
        S_DRAIN:  if (drn_last) state_d = stage_last ? S_UNLOAD : S_CALC;
        S_UNLOAD: if (un_last) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_cnt_d    = ld_cnt_q;
    cyc_d       = cyc_q;
    stage_d     = stage_q;
    drn_d       = drn_q;
    un_cnt_d    = un_cnt_q;
    out_valid_d = out_valid_q;
    conj_d      = conj_q;
    sig_d       = sig_q;
    case (state_q)
      S_IDLE: if (start) begin
        conj_d = is_ifft;
        sig_d  = sig_num;
      end
      S_LOAD: if (ld_beat) begin
        ld_cnt_d = (ld_cnt_q == {LOG2N{1'b1}}) ? '0 : ld_cnt_q + 1'b1;
        stage_d  = '0;
        cyc_d    = '0;
      end
      S_CALC: begin
        cyc_d = cyc_last ? '0 : cyc_q + 1'b1;
        drn_d = '0;
      end
      S_DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_last) begin
          drn_d   = '0;
          stage_d = stage_last ? '0 : stage_q + 1'b1;
        end
      end
      S_UNLOAD: begin
        if (un_issue)       out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        if (un_issue) un_cnt_d = un_cnt_q + 1'b1;
        if (un_last) begin
          un_cnt_d    = '0;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (abort) begin
      ld_cnt_d    = '0;
      cyc_d       = '0;
      stage_d     = '0;
      drn_d       = '0;
      un_cnt_d    = '0;
      out_valid_d = 1'b0;
      conj_d      = conj_q;
      sig_d       = sig_q;
    end
  end

  // write-back delay line: issue flag and addresses march BF_LAT cycles to the RAM write port
  always_comb begin
    vld_pipe_d = '0;
    pa_d       = '0;
    pb_d       = '0;
    if (!abort) begin
      vld_pipe_d[0] = (state_q == S_CALC);
      pa_d[0]       = calc_a;
      pb_d[0]       = calc_b;
      for (int i = 1; i < BF_LAT; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        pa_d[i]       = pa_q[i-1];
        pb_d[i]       = pb_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q    <= '0;
      cyc_q       <= '0;
      stage_q     <= '0;
      drn_q       <= '0;
      un_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      conj_q      <= 1'b0;
      sig_q       <= '0;
      vld_pipe_q  <= '0;
      pa_q        <= '0;
      pb_q        <= '0;
    end else begin
      ld_cnt_q    <= ld_cnt_d;
      cyc_q       <= cyc_d;
      stage_q     <= stage_d;
      drn_q       <= drn_d;
      un_cnt_q    <= un_cnt_d;
      out_valid_q <= out_valid_d;
      conj_q      <= conj_d;
      sig_q       <= sig_d;
      vld_pipe_q  <= vld_pipe_d;
      pa_q        <= pa_d;
      pb_q        <= pb_d;
    end
  end

  always_comb begin
    in_ready    = (state_q == S_LOAD);
    rd_en       = 1'b0;
    rd_addr_a   = '0;
    rd_addr_b   = '0;
    tw_idx      = '0;
    wr_en       = 1'b0;
    wr_sel_ext  = 1'b0;
    wr_addr_a   = '0;
    wr_addr_b   = '0;
    case (state_q)
      S_LOAD: if (in_valid) begin
        wr_en      = 1'b1;
        wr_sel_ext = 1'b1;
        wr_addr_a  = ld_rev;
      end
      S_CALC: begin
        rd_en     = 1'b1;
        rd_addr_a = calc_a;
        rd_addr_b = calc_b;
        tw_idx    = calc_tw;
      end
      S_UNLOAD: begin
        rd_en     = un_issue;
        rd_addr_a = un_cnt_q[LOG2N-1:0];
      end
      default: ;
    endcase
    if (vld_pipe_q[BF_LAT-1]) begin
      wr_en      = 1'b1;
      wr_sel_ext = 1'b0;
      wr_addr_a  = pa_q[BF_LAT-1];
      wr_addr_b  = pb_q[BF_LAT-1];
    end
    out_valid   = out_valid_q;
    done        = un_last;
    busy        = (state_q != S_IDLE);
    conj_tw     = conj_q;
    sig_num_out = sig_q;
  end

endmodule
